// File: rtl/latch_exerciser.sv
// Stimulus driver and checker for an active-low set/reset, inverted-output,
// transparent-high latch cell: paced D/CLK/SETB/RSTB activity with QN checking.
module latch_exerciser #(
  parameter int          NUM_VEC     = 256,
  parameter int          SETUP_CYC   = 2,
  parameter int          PW_CYC      = 2,
  parameter int          HOLD_CYC    = 1,
  parameter int          ASYNC_EVERY = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        start,
  output logic        cut_d,
  output logic        cut_clk,
  output logic        cut_setb,
  output logic        cut_rstb,
  input  logic        cut_qn,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD    = 4'd1;
  localparam logic [3:0] SETUP   = 4'd2;
  localparam logic [3:0] OPEN    = 4'd3;
  localparam logic [3:0] CLOSE   = 4'd4;
  localparam logic [3:0] CHECK   = 4'd5;
  localparam logic [3:0] ASSERT  = 4'd6;
  localparam logic [3:0] RECOVER = 4'd7;
  localparam logic [3:0] FINISH  = 4'd8;

  localparam logic [7:0]  SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  PW_LD     = 8'(PW_CYC - 1);
  localparam logic [7:0]  HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [15:0] NUM_VEC_W = 16'(NUM_VEC);
  localparam logic [15:0] ASYNC_W   = 16'(ASYNC_EVERY);

  logic [3:0]  state;
  logic [7:0]  dly;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] vec_nxt;
  logic [15:0] err_nxt;
  logic [15:0] since_async;
  logic        expected;
  logic        set_next;
  logic        mismatch;
  logic        async_hit;

  always_comb begin
    lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    vec_nxt   = vec_cnt + 16'd1;
    err_nxt   = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
    mismatch  = (cut_qn != expected);
    async_hit = (ASYNC_EVERY != 0) && ((since_async + 16'd1) == ASYNC_W);
  end

  // The set/reset alternation and the LFSR survive across runs; only RSTB restarts them.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state       <= IDLE;
      dly         <= 8'd0;
      lfsr        <= SEED;
      since_async <= 16'd0;
      expected    <= 1'b1;
      set_next    <= 1'b1;
      cut_d       <= 1'b0;
      cut_clk     <= 1'b0;
      cut_setb    <= 1'b1;
      cut_rstb    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      vec_cnt     <= 16'd0;
      err_cnt     <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec_cnt     <= 16'd0;
            err_cnt     <= 16'd0;
            since_async <= 16'd0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          lfsr  <= lfsr_nxt;
          cut_d <= lfsr_nxt[0];
          dly   <= SETUP_LD;
          state <= SETUP;
        end
        SETUP: begin
          if (dly == 8'd0) begin
            cut_clk  <= 1'b1;
            expected <= ~cut_d;
            dly      <= PW_LD;
            state    <= OPEN;
          end else begin
            dly <= dly - 8'd1;
          end
        end
        OPEN: begin
          if (dly == 8'd0) begin
            cut_clk <= 1'b0;
            dly     <= HOLD_LD;
            state   <= CLOSE;
          end else begin
            dly <= dly - 8'd1;
          end
        end
        CLOSE: begin
          if (dly == 8'd0) state <= CHECK;
          else             dly   <= dly - 8'd1;
        end
        CHECK: begin
          if (mismatch) err_cnt <= err_nxt;
          vec_cnt <= vec_nxt;
          since_async <= async_hit ? 16'd0 : since_async + 16'd1;
          if (vec_nxt == NUM_VEC_W) begin
            state <= FINISH;
          end else if (async_hit) begin
            if (set_next) begin
              cut_setb <= 1'b0;
              expected <= 1'b0;
            end else begin
              cut_rstb <= 1'b0;
              expected <= 1'b1;
            end
            set_next <= ~set_next;
            dly      <= PW_LD;
            state    <= ASSERT;
          end else begin
            state <= LOAD;
          end
        end
        ASSERT: begin
          if (dly == 8'd0) begin
            if (mismatch) err_cnt <= err_nxt;
            cut_setb <= 1'b1;
            cut_rstb <= 1'b1;
            dly      <= SETUP_LD;
            state    <= RECOVER;
          end else begin
            dly <= dly - 8'd1;
          end
        end
        RECOVER: begin
          if (dly == 8'd0) state <= LOAD;
          else             dly   <= dly - 8'd1;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_exerciser.sv
// Bench for latch_exerciser: behavioural latch cell plus a per-run expected
// waveform built vector-by-vector from the LFSR, compared every cycle.
module tb_latch_exerciser;

  localparam int          NUM_VEC     = 16;
  localparam int          SETUP_CYC   = 2;
  localparam int          PW_CYC      = 2;
  localparam int          HOLD_CYC    = 1;
  localparam int          ASYNC_EVERY = 8;
  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          VEC_LEN     = 1 + SETUP_CYC + PW_CYC + HOLD_CYC + 1;

  typedef struct {
    logic d, clk, setb, rstb, busy, done;
    int   vec;
    int   errc;
  } entry_t;

  logic        CLK;
  logic        RSTB;
  logic        start;
  logic        cut_d, cut_clk, cut_setb, cut_rstb, cut_qn;
  logic        busy, done;
  logic [15:0] vec_cnt, err_cnt;

  int          checks = 0;
  int          errors = 0;
  int          qn_mode = 0;
  logic        lat_qn = 1'b1;

  entry_t      trace[$];
  entry_t      idle_e;
  int          idx = 0;
  logic        tracing = 1'b0;
  int          err_offset = 0;
  logic [15:0] m_lfsr;
  logic        m_d;
  logic        m_set_next;
  int          cycle_cnt = 0;
  int          start_cycle = 0;
  int          done_cycle = 0;
  int          done_count = 0;
  int          setb_low = 0;
  int          rstb_low = 0;

  latch_exerciser #(
    .NUM_VEC(NUM_VEC), .SETUP_CYC(SETUP_CYC), .PW_CYC(PW_CYC),
    .HOLD_CYC(HOLD_CYC), .ASYNC_EVERY(ASYNC_EVERY), .SEED(SEED)
  ) dut (
    .CLK(CLK), .RSTB(RSTB), .start(start),
    .cut_d(cut_d), .cut_clk(cut_clk), .cut_setb(cut_setb), .cut_rstb(cut_rstb),
    .cut_qn(cut_qn), .busy(busy), .done(done),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural cell: set dominates, then reset, then transparent while CLK high.
  always @(cut_d or cut_clk or cut_setb or cut_rstb) begin
    if (!cut_setb)      lat_qn = 1'b0;
    else if (!cut_rstb) lat_qn = 1'b1;
    else if (cut_clk)   lat_qn = ~cut_d;
  end
  assign cut_qn = (qn_mode == 1) ? 1'b0 : (qn_mode == 2) ? 1'b1 : lat_qn;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic entry_t mk(input logic d, input logic clk, input logic setb,
                                input logic rstb, input logic bsy, input logic dn,
                                input int vec, input int errc);
    entry_t e;
    e.d = d; e.clk = clk; e.setb = setb; e.rstb = rstb;
    e.busy = bsy; e.done = dn; e.vec = vec; e.errc = errc;
    return e;
  endfunction

  function automatic logic qn_wrong(input logic want_qn);
    return (qn_mode == 1 && want_qn !== 1'b0) || (qn_mode == 2 && want_qn !== 1'b1);
  endfunction

  task automatic reset_model();
    m_lfsr     = SEED;
    m_d        = 1'b0;
    m_set_next = 1'b1;
    err_offset = 0;
    idle_e     = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // Expected outputs after each clock edge of a run, indexed from the start-sampling edge.
  task automatic build_trace();
    int   vec;
    int   errc;
    logic old_d;
    logic set_ev;
    trace.delete();
    vec = 0;
    errc = 0;
    for (int v = 0; v < NUM_VEC; v++) begin
      old_d  = m_d;
      m_lfsr = lfsr_next(m_lfsr);
      m_d    = m_lfsr[0];
      for (int o = 0; o < VEC_LEN; o++)
        trace.push_back(mk((o == 0) ? old_d : m_d,
                           (o >= 1 + SETUP_CYC && o < 1 + SETUP_CYC + PW_CYC),
                           1'b1, 1'b1, 1'b1, 1'b0, vec, errc));
      if (qn_wrong(~m_d)) errc++;
      vec++;
      if (vec == NUM_VEC) begin
        trace.push_back(mk(m_d, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, vec, errc));
        trace.push_back(mk(m_d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, vec, errc));
        trace.push_back(mk(m_d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, vec, errc));
      end else if (ASYNC_EVERY != 0 && vec % ASYNC_EVERY == 0) begin
        set_ev = m_set_next;
        for (int o = 0; o < PW_CYC + SETUP_CYC; o++) begin
          if (o == PW_CYC && qn_wrong(~set_ev)) errc++;
          trace.push_back(mk(m_d, 1'b0, !(set_ev && o < PW_CYC),
                             !(!set_ev && o < PW_CYC), 1'b1, 1'b0, vec, errc));
        end
        m_set_next = !m_set_next;
      end
    end
  endtask

  task automatic do_compare();
    entry_t     e;
    int         want_err;
    logic [5:0] got;
    logic [5:0] want;
    if (tracing && idx < int'(trace.size())) begin
      e = trace[idx];
      idx++;
      idle_e = e;
    end else begin
      e = idle_e;
    end
    want_err = e.errc + err_offset;
    if (want_err > 65535) want_err = 65535;
    got  = {cut_d, cut_clk, cut_setb, cut_rstb, busy, done};
    want = {e.d, e.clk, e.setb, e.rstb, e.busy, e.done};
    checks++;
    if (got !== want || vec_cnt !== 16'(e.vec) || err_cnt !== 16'(want_err)) begin
      errors++;
      $display("[TB] FAIL cycle%0d d/clk/setb/rstb/busy/done=%b vec=%0d err=%0d, want %b vec=%0d err=%0d",
               cycle_cnt, got, vec_cnt, err_cnt, want, e.vec, want_err);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic waitIdx(input int target);
    int guard;
    guard = 0;
    while (idx < target && guard < 2000) begin
      @(posedge CLK);
      #3;
      guard++;
    end
    if (idx < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout: reached %0d, want %0d", idx, target);
    end
  endtask

  task automatic beginRun(input int mode);
    @(negedge CLK);
    qn_mode = mode;
    build_trace();
    err_offset  = 0;
    idx         = 0;
    tracing     = 1'b1;
    done_count  = 0;
    setb_low    = 0;
    rstb_low    = 0;
    start_cycle = cycle_cnt + 1;
    start       = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int mode, input bit preload, input bit repulse);
    beginRun(mode);
    if (preload) begin
      waitIdx(2);
      force dut.err_cnt = 16'hFFFE;
      err_offset = 65534;
      @(posedge CLK);
      #3;
      release dut.err_cnt;
    end
    if (repulse) begin
      for (int k = 0; k < 2; k++) begin
        waitIdx(30 + 40 * k);
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
      end
    end
    waitIdx(int'(trace.size()));
  endtask

  initial begin
    logic [15:0] s;
    RSTB  = 1'b0;
    start = 1'b0;
    reset_model();
    fork
      forever begin
        @(posedge CLK);
        cycle_cnt++;
        #2;
        do_compare();
        if (done === 1'b1) begin
          done_count++;
          done_cycle = cycle_cnt;
        end
        if (cut_setb === 1'b0) setb_low++;
        if (cut_rstb === 1'b0) rstb_low++;
      end
      begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
      end
    join_none

    repeat (3) @(negedge CLK);
    checkOutput("reset_state", 64'({cut_d, cut_clk, cut_setb, cut_rstb, busy, done, vec_cnt, err_cnt}),
                64'({6'b001100, 32'h0}));
    @(negedge CLK);
    RSTB = 1'b1;
    repeat (2) @(negedge CLK);

    s = SEED;
    for (int k = 0; k < 4; k++) s = lfsr_next(s);
    checkOutput("model_lfsr_4_steps", 64'(s), 64'h2ACE);

    $display("[TB] run 1: normal, set pulse after vector 8");
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("run1_vec_cnt", 64'(vec_cnt), 64'd16);
    checkOutput("run1_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("run1_done_count", 64'(done_count), 64'd1);
    checkOutput("run1_done_latency", 64'(done_cycle - start_cycle), 64'd117);
    checkOutput("run1_setb_low_cycles", 64'(setb_low), 64'd2);
    checkOutput("run1_rstb_low_cycles", 64'(rstb_low), 64'd0);

    $display("[TB] run 2: normal, reset pulse continues the alternation");
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("run2_setb_low_cycles", 64'(setb_low), 64'd0);
    checkOutput("run2_rstb_low_cycles", 64'(rstb_low), 64'd2);
    checkOutput("run2_err_cnt", 64'(err_cnt), 64'd0);

    $display("[TB] run 3: QN stuck at 0");
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("run3_vec_cnt", 64'(vec_cnt), 64'd16);
    checkOutput("run3_err_cnt", 64'(err_cnt), 64'(trace[trace.size() - 1].errc));

    $display("[TB] run 4: QN stuck at 1 with counter preloaded near full scale");
    applyStimulus(2, 1'b1, 1'b0);
    checkOutput("run4_err_saturated", 64'(err_cnt), 64'hFFFF);

    $display("[TB] run 5: reset during the open window of vector 3");
    beginRun(0);
    waitIdx(2 * VEC_LEN + 1 + SETUP_CYC + 1);
    tracing = 1'b0;
    reset_model();
    RSTB = 1'b0;
    #1;
    checkOutput("abort_outputs", 64'({cut_d, cut_clk, cut_setb, cut_rstb, busy, done, vec_cnt, err_cnt}),
                64'({6'b001100, 32'h0}));
    repeat (3) @(negedge CLK);
    RSTB = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("abort_no_done", 64'(done_count), 64'd0);

    $display("[TB] run 6: fresh run, start re-pulsed while busy");
    applyStimulus(0, 1'b0, 1'b1);
    checkOutput("run6_vec_cnt", 64'(vec_cnt), 64'd16);
    checkOutput("run6_done_count", 64'(done_count), 64'd1);
    checkOutput("run6_done_latency", 64'(done_cycle - start_cycle), 64'd117);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch_exerciser.md
Name: latch_exerciser

Overview:
- Sequential stimulus driver and checker for the active-low set/reset, inverted-output transparent-high latch cell (cell-under-test, CUT).
- Drives the CUT's D, CLK, SETB and RSTB pins, spacing every edge to respect the cell's setup, hold, recovery and pulse-width rules.
- Samples QN and compares it against an internal reference model.
- Used in power/characterisation benches to toggle the latch through data, set and reset activity with a reproducible pseudo-random pattern.

Parameters:
- NUM_VEC, 256, number of data vectors per run (1..65535).
- SETUP_CYC, 2, cycles D is stable before the latch clock rises (>=1).
- PW_CYC, 2, cycles the latch clock stays high, i.e. the transparent window (>=1).
- HOLD_CYC, 1, cycles D is held after the latch clock falls (>=1).
- ASYNC_EVERY, 16, an async event is inserted after every ASYNC_EVERY vectors (0 = never).
- SEED, 16'hACE1, initial value of the 16-bit LFSR.

Ports:
- CLK  input  1  bench clock; all state changes on rising edge.
- RSTB  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- cut_d  output  1  drives CUT D.
- cut_clk  output  1  drives CUT CLK.
- cut_setb  output  1  drives CUT SETB.
- cut_rstb  output  1  drives CUT RSTB.
- cut_qn  input  1  CUT QN, already synchronous to CLK.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at the end of a run.
- vec_cnt  output  16  vectors completed in the current run.
- err_cnt  output  16  mismatches in the current run; saturates at 16'hFFFF.

Behaviour:
- Reset (RSTB low) values:
  - cut_d=0, cut_clk=0, cut_setb=1, cut_rstb=1.
  - busy=0, done=0, vec_cnt=0, err_cnt=0.
  - LFSR=SEED; state=IDLE; expected-QN model=1.
- Reset asserted mid-run aborts the run immediately with no done pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per vector in LOAD. cut_d takes bit 0 of the advanced value.
- All CUT outputs are registered. No combinational path from cut_qn to any output.
- States and transitions:
  - IDLE: busy=0. On start: clear vec_cnt and err_cnt, busy=1, go to LOAD.
  - LOAD: advance the LFSR and drive cut_d. Go to SETUP.
  - SETUP: hold for SETUP_CYC cycles. Go to OPEN, setting cut_clk=1.
  - OPEN: hold for PW_CYC cycles. The model sets expected=~cut_d (transparent). Go to CLOSE, setting cut_clk=0.
  - CLOSE: hold cut_d for HOLD_CYC cycles. Go to CHECK.
  - CHECK (1 cycle): compare cut_qn with expected; on mismatch, err_cnt+1 (saturating). vec_cnt+1. Then, in priority order:
    - vec_cnt reached NUM_VEC → FINISH.
    - ASYNC_EVERY!=0 and vec_cnt mod ASYNC_EVERY==0 → ASSERT.
    - otherwise → LOAD.
  - ASSERT: cut_clk stays 0 throughout. Drive the event for PW_CYC cycles:
    - Events alternate per insertion, starting with set: set pulse (cut_setb=0, expected=0), then reset pulse (cut_rstb=0, expected=1).
    - On the last cycle of the pulse, compare cut_qn and update err_cnt as in CHECK. vec_cnt is not incremented.
    - Release the pin and go to RECOVER.
  - RECOVER: hold for SETUP_CYC cycles so the next latch-clock edge meets recovery. The expected value is retained: the latch is opaque and holds. Go to LOAD.
  - FINISH: busy=0, done=1 for one cycle. Go to IDLE. The LFSR is not reseeded, so the next run continues the sequence.
- cut_setb and cut_rstb are never low simultaneously. cut_clk is never high while either is low.
- start while busy is ignored.
- Delay counter width is 8 bits. Parameters above 255 are illegal.
- Cycles per vector = 1 + SETUP_CYC + PW_CYC + HOLD_CYC + 1.

Test Plan:
- Defaults, behavioural CUT model, ASYNC_EVERY=0, NUM_VEC=4; pulse start:
  - cut_d follows LFSR bit 0 from 16'hACE1.
  - cut_clk high for exactly 2 cycles, 2 cycles after each cut_d change.
  - done pulses 1+4×7 cycles after start.
  - Final vec_cnt=4, err_cnt=0.
- NUM_VEC=32, ASYNC_EVERY=16:
  - After vector 16, cut_setb is low for 2 cycles and cut_qn=0.
  - After vector 32, the run finishes: done pulses with no cut_rstb pulse.
- CUT QN forced stuck-at-0 for 8 vectors → err_cnt equals the count of vectors with cut_d=0 (about 4), vec_cnt=8.
- Stuck-at-1 QN with err_cnt preloaded via force to 16'hFFFE, 4 mismatches → err_cnt saturates at 16'hFFFF.
- RSTB asserted during OPEN of vector 3:
  - Outputs immediately return to reset values and done stays 0.
  - After release, start begins a fresh run with vec_cnt cleared.
- start re-pulsed while busy → no effect: vec_cnt is continuous and exactly one done pulse occurs.
